// File: rtl/sha_pkg.sv
// Shared definitions for the SHA-2 logical-function datapath: opcodes,
// rotation/shift amounts for SHA-256 and SHA-512, and rotate/shift helpers.
package sha_pkg;

  typedef enum logic [2:0] {
    OP_CH    = 3'd0,
    OP_MAJ   = 3'd1,
    OP_BSIG0 = 3'd2,
    OP_BSIG1 = 3'd3,
    OP_SSIG0 = 3'd4,
    OP_SSIG1 = 3'd5
  } sha_op_e;

  // Row order: BSIG0, BSIG1, SSIG0, SSIG1. For the SSIG rows the third
  // amount is a zero-fill right shift instead of a rotation.
  localparam int unsigned SHA256_AMT [4][3] = '{
    '{ 2, 13, 22},
    '{ 6, 11, 25},
    '{ 7, 18,  3},
    '{17, 19, 10}
  };

  localparam int unsigned SHA512_AMT [4][3] = '{
    '{28, 34, 39},
    '{14, 18, 41},
    '{ 1,  8,  7},
    '{19, 61,  6}
  };

  function automatic int unsigned sig_amt(input int unsigned w,
                                          input int unsigned row,
                                          input int unsigned idx);
    return (w == 64) ? SHA512_AMT[row][idx] : SHA256_AMT[row][idx];
  endfunction

  // Words are carried in a 64-bit container; a 32-bit word lives in [31:0]
  // and rotates within those bits only.
  function automatic logic [63:0] rotr(input logic [63:0] x,
                                       input int unsigned n,
                                       input int unsigned w);
    logic [63:0] r;
    if (w == 32) begin
      r = {32'h0, (x[31:0] >> n) | (x[31:0] << (32 - n))};
    end else begin
      r = (x >> n) | (x << (64 - n));
    end
    return r;
  endfunction

  function automatic logic [63:0] shr(input logic [63:0] x,
                                      input int unsigned n,
                                      input int unsigned w);
    logic [63:0] r;
    if (w == 32) begin
      r = {32'h0, x[31:0] >> n};
    end else begin
      r = x >> n;
    end
    return r;
  endfunction

endpackage

// File: rtl/sha_logic_core.sv
// Combinational evaluation of one SHA-2 logical function (Ch, Maj, the two
// big sigmas and the two small sigmas) for 32- or 64-bit words.
module sha_logic_core
  import sha_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [WIDTH-1:0] c,
  output logic [WIDTH-1:0] data,
  output logic             err
);

  localparam int unsigned W = WIDTH;

  if (WIDTH != 32 && WIDTH != 64) begin : g_bad_width
    $error("sha_logic_core: WIDTH must be 32 or 64");
  end

  logic [63:0] a64;
  logic [63:0] b64;
  logic [63:0] c64;
  logic [63:0] r64;
  sha_op_e     op_e;

  assign a64  = 64'(a);
  assign b64  = 64'(b);
  assign c64  = 64'(c);
  assign op_e = sha_op_e'(op);

  // NOTE: every variable written in an always_comb block gets a default at
  // the top; a path that leaves one unassigned would infer a latch.
  always_comb begin
    r64 = '0;
    err = 1'b0;
    case (op_e)
      OP_CH:    r64 = (a64 & b64) ^ (~a64 & c64);
      OP_MAJ:   r64 = (a64 & b64) ^ (a64 & c64) ^ (b64 & c64);
      OP_BSIG0: r64 = rotr(a64, sig_amt(W, 0, 0), W) ^
                      rotr(a64, sig_amt(W, 0, 1), W) ^
                      rotr(a64, sig_amt(W, 0, 2), W);
      OP_BSIG1: r64 = rotr(a64, sig_amt(W, 1, 0), W) ^
                      rotr(a64, sig_amt(W, 1, 1), W) ^
                      rotr(a64, sig_amt(W, 1, 2), W);
      OP_SSIG0: r64 = rotr(a64, sig_amt(W, 2, 0), W) ^
                      rotr(a64, sig_amt(W, 2, 1), W) ^
                      shr (a64, sig_amt(W, 2, 2), W);
      OP_SSIG1: r64 = rotr(a64, sig_amt(W, 3, 0), W) ^
                      rotr(a64, sig_amt(W, 3, 1), W) ^
                      shr (a64, sig_amt(W, 3, 2), W);
      default: begin
        r64 = '0;
        err = 1'b1;
      end
    endcase
  end

  assign data = r64[WIDTH-1:0];

endmodule

// File: rtl/sha_logic_pipe.sv
// Pipelined SHA-2 logical-function unit with valid/ready on both sides.
// Stage 1 evaluates the function; later stages are elastic delay registers.
module sha_logic_pipe
  import sha_pkg::*;
#(
  parameter int WIDTH  = 32,
  parameter int STAGES = 2,
  parameter int TAG_W  = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [2:0]       in_op,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic [WIDTH-1:0] in_c,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic [TAG_W-1:0] out_tag,
  output logic             out_err,
  output logic             busy
);

  if (WIDTH != 32 && WIDTH != 64) begin : g_bad_width
    $error("sha_logic_pipe: WIDTH must be 32 or 64");
  end
  if (STAGES < 1 || STAGES > 4) begin : g_bad_stages
    $error("sha_logic_pipe: STAGES must be in 1..4");
  end

  logic [WIDTH-1:0] core_data;
  logic             core_err;

  sha_logic_core #(.WIDTH(WIDTH)) u_core (
    .op   (in_op),
    .a    (in_a),
    .b    (in_b),
    .c    (in_c),
    .data (core_data),
    .err  (core_err)
  );

  logic [STAGES-1:0] valid_q, valid_d;
  logic [STAGES-1:0] err_q,   err_d;
  logic [WIDTH-1:0]  data_q [STAGES];
  logic [WIDTH-1:0]  data_d [STAGES];
  logic [TAG_W-1:0]  tag_q  [STAGES];
  logic [TAG_W-1:0]  tag_d  [STAGES];
  logic [STAGES-1:0] load;

  always_comb begin
    // A stage accepts new contents when it is empty or its occupant moves on;
    // evaluated from the output end so ready ripples back through full stages.
    load[STAGES-1] = !valid_q[STAGES-1] || out_ready;
    for (int k = STAGES - 2; k >= 0; k--) begin
      load[k] = !valid_q[k] || load[k+1];
    end

    valid_d   = valid_q;
    err_d     = err_q;
    data_d    = data_q;
    tag_d     = tag_q;

    if (load[0]) begin
      valid_d[0] = in_valid;
      if (in_valid) begin
        data_d[0] = core_data;
        tag_d[0]  = in_tag;
        err_d[0]  = core_err;
      end
    end

    for (int k = 1; k < STAGES; k++) begin
      if (load[k]) begin
        valid_d[k] = valid_q[k-1];
        if (valid_q[k-1]) begin
          data_d[k] = data_q[k-1];
          tag_d[k]  = tag_q[k-1];
          err_d[k]  = err_q[k-1];
        end
      end
    end
  end

  // NOTE: sequential state uses non-blocking assignments only, so every flop
  // samples the pre-edge value of its neighbour regardless of statement order.
  // NOTE: the stage arrays are a handful of pipeline registers, not a memory,
  // so they are cleared on reset to give defined zero outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q <= '0;
      err_q   <= '0;
      for (int k = 0; k < STAGES; k++) begin
        data_q[k] <= '0;
        tag_q[k]  <= '0;
      end
    end else begin
      valid_q <= valid_d;
      err_q   <= err_d;
      for (int k = 0; k < STAGES; k++) begin
        data_q[k] <= data_d[k];
        tag_q[k]  <= tag_d[k];
      end
    end
  end

  assign in_ready  = load[0];
  assign out_valid = valid_q[STAGES-1];
  assign out_data  = data_q[STAGES-1];
  assign out_tag   = tag_q[STAGES-1];
  assign out_err   = err_q[STAGES-1];
  assign busy      = |valid_q;

endmodule

// File: tb/tb_sha_logic_pipe.sv
// Directed bench for sha_logic_pipe: a 32-bit/2-stage build and a
// 64-bit/1-stage build sharing one clock and reset.
module tb_sha_logic_pipe;

  logic clk;
  logic rst;

  logic        in_valid32, in_ready32, out_valid32, out_ready32, out_err32, busy32;
  logic [2:0]  in_op32;
  logic [31:0] a32, b32, c32, out_data32;
  logic [3:0]  tag32, out_tag32;

  logic        in_valid64, in_ready64, out_valid64, out_ready64, out_err64, busy64;
  logic [2:0]  in_op64;
  logic [63:0] a64, b64, c64, out_data64;
  logic [3:0]  tag64, out_tag64;

  int n_cmp;
  int n_bad;

  sha_logic_pipe #(.WIDTH(32), .STAGES(2), .TAG_W(4)) u_dut32 (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid32),
    .in_ready  (in_ready32),
    .in_op     (in_op32),
    .in_a      (a32),
    .in_b      (b32),
    .in_c      (c32),
    .in_tag    (tag32),
    .out_valid (out_valid32),
    .out_ready (out_ready32),
    .out_data  (out_data32),
    .out_tag   (out_tag32),
    .out_err   (out_err32),
    .busy      (busy32)
  );

  sha_logic_pipe #(.WIDTH(64), .STAGES(1), .TAG_W(4)) u_dut64 (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid64),
    .in_ready  (in_ready64),
    .in_op     (in_op64),
    .in_a      (a64),
    .in_b      (b64),
    .in_c      (c64),
    .in_tag    (tag64),
    .out_valid (out_valid64),
    .out_ready (out_ready64),
    .out_data  (out_data64),
    .out_tag   (out_tag64),
    .out_err   (out_err64),
    .busy      (busy64)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp)
    else begin
      n_bad++;
      $error("FAIL %s: observed %h expected %h", name, obs, exp);
    end
  endtask

  task automatic drive32(input logic [2:0] op, input logic [31:0] a,
                         input logic [31:0] b, input logic [31:0] c,
                         input logic [3:0] tag);
    in_valid32 = 1'b1;
    in_op32    = op;
    a32        = a;
    b32        = b;
    c32        = c;
    tag32      = tag;
  endtask

  task automatic chk_out32(input string name, input logic [31:0] data,
                           input logic [3:0] tag, input logic err);
    chk({name, ".valid"}, 64'(out_valid32), 64'(1'b1));
    chk({name, ".data"},  64'(out_data32),  64'(data));
    chk({name, ".tag"},   64'(out_tag32),   64'(tag));
    chk({name, ".err"},   64'(out_err32),   64'(err));
  endtask

  initial begin
    n_cmp = 0;
    n_bad = 0;
    rst = 1'b1;
    in_valid32 = 1'b0; out_ready32 = 1'b1; in_op32 = '0;
    a32 = '0; b32 = '0; c32 = '0; tag32 = '0;
    in_valid64 = 1'b0; out_ready64 = 1'b1; in_op64 = '0;
    a64 = '0; b64 = '0; c64 = '0; tag64 = '0;

    // Reset state
    step();
    step();
    chk("rst.out_valid32", 64'(out_valid32), 64'(1'b0));
    chk("rst.out_data32",  64'(out_data32),  64'h0);
    chk("rst.out_tag32",   64'(out_tag32),   64'h0);
    chk("rst.out_err32",   64'(out_err32),   64'(1'b0));
    chk("rst.busy32",      64'(busy32),      64'(1'b0));
    chk("rst.out_valid64", 64'(out_valid64), 64'(1'b0));
    chk("rst.busy64",      64'(busy64),      64'(1'b0));
    rst = 1'b0;
    step();
    chk("rst.in_ready32", 64'(in_ready32), 64'(1'b1));
    chk("rst.in_ready64", 64'(in_ready64), 64'(1'b1));

    // CH with two-cycle latency
    drive32(3'd0, 32'hFFFF0000, 32'h12345678, 32'h9ABCDEF0, 4'd0);
    chk("ch.in_ready", 64'(in_ready32), 64'(1'b1));
    step();
    in_valid32 = 1'b0;
    chk("ch.lat1", 64'(out_valid32), 64'(1'b0));
    chk("ch.busy", 64'(busy32), 64'(1'b1));
    step();
    chk_out32("ch", 32'h1234DEF0, 4'd0, 1'b0);
    step();
    chk("ch.drain", 64'(out_valid32), 64'(1'b0));

    // MAJ then BSIG0 back-to-back
    drive32(3'd1, 32'hF0F0F0F0, 32'hFF00FF00, 32'h0F0F0F0F, 4'd1);
    step();
    drive32(3'd2, 32'h6A09E667, 32'h0, 32'h0, 4'd2);
    step();
    in_valid32 = 1'b0;
    chk_out32("maj", 32'hFF00FF00, 4'd1, 1'b0);
    step();
    chk_out32("bsig0", 32'hCE20B47E, 4'd2, 1'b0);
    step();
    chk("bsig0.drain", 64'(out_valid32), 64'(1'b0));

    // SSIG0, reserved op 6, SSIG0 exercising the zero-fill shift
    drive32(3'd4, 32'h00000001, 32'h0, 32'h0, 4'd3);
    step();
    drive32(3'd6, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, 4'd4);
    step();
    drive32(3'd4, 32'h80000000, 32'h0, 32'h0, 4'd12);
    chk_out32("ssig0", 32'h02004000, 4'd3, 1'b0);
    step();
    in_valid32 = 1'b0;
    chk_out32("rsvd", 32'h00000000, 4'd4, 1'b1);
    step();
    chk_out32("ssig0_msb", 32'h11002000, 4'd12, 1'b0);
    step();

    // Stall with five streamed inputs
    out_ready32 = 1'b0;
    drive32(3'd0, 32'hFFFF0000, 32'h12345678, 32'h9ABCDEF0, 4'd5);
    chk("stall.rdy0", 64'(in_ready32), 64'(1'b1));
    step();
    drive32(3'd1, 32'hF0F0F0F0, 32'hFF00FF00, 32'h0F0F0F0F, 4'd6);
    chk("stall.rdy1", 64'(in_ready32), 64'(1'b1));
    step();
    drive32(3'd3, 32'h00000001, 32'h0, 32'h0, 4'd7);
    chk("stall.full_rdy_a", 64'(in_ready32), 64'(1'b0));
    chk_out32("stall.hold_a", 32'h1234DEF0, 4'd5, 1'b0);
    step();
    chk("stall.full_rdy_b", 64'(in_ready32), 64'(1'b0));
    chk_out32("stall.hold_b", 32'h1234DEF0, 4'd5, 1'b0);
    step();
    chk_out32("stall.hold_c", 32'h1234DEF0, 4'd5, 1'b0);
    out_ready32 = 1'b1;
    #1;
    chk("stall.release_rdy", 64'(in_ready32), 64'(1'b1));
    step();
    drive32(3'd5, 32'h00000001, 32'h0, 32'h0, 4'd8);
    chk_out32("stall.o1", 32'hFF00FF00, 4'd6, 1'b0);
    step();
    drive32(3'd0, 32'h00000000, 32'h5555AAAA, 32'hDEADBEEF, 4'd9);
    chk_out32("stall.o2", 32'h04200080, 4'd7, 1'b0);
    step();
    in_valid32 = 1'b0;
    chk_out32("stall.o3", 32'h0000A000, 4'd8, 1'b0);
    step();
    chk_out32("stall.o4", 32'hDEADBEEF, 4'd9, 1'b0);
    step();
    chk("stall.drain", 64'(out_valid32), 64'(1'b0));
    chk("stall.idle", 64'(busy32), 64'(1'b0));

    // Reset with two transactions in flight
    out_ready32 = 1'b0;
    drive32(3'd0, 32'hFFFF0000, 32'h12345678, 32'h9ABCDEF0, 4'd10);
    step();
    drive32(3'd1, 32'hF0F0F0F0, 32'hFF00FF00, 32'h0F0F0F0F, 4'd11);
    step();
    in_valid32  = 1'b0;
    out_ready32 = 1'b1;
    chk("mid.full", 64'(busy32), 64'(1'b1));
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("mid.out_valid", 64'(out_valid32), 64'(1'b0));
    chk("mid.busy",      64'(busy32),      64'(1'b0));
    chk("mid.out_data",  64'(out_data32),  64'h0);
    chk("mid.out_tag",   64'(out_tag32),   64'h0);
    chk("mid.in_ready",  64'(in_ready32),  64'(1'b1));
    for (int i = 0; i < 3; i++) begin
      step();
      chk("mid.no_stale", 64'(out_valid32), 64'(1'b0));
    end

    // SHA-512 build, one stage: SSIG0 then BSIG0 back-to-back
    in_valid64 = 1'b1;
    in_op64    = 3'd4;
    a64        = 64'h0000000000000001;
    tag64      = 4'd13;
    chk("w64.in_ready", 64'(in_ready64), 64'(1'b1));
    step();
    in_op64 = 3'd2;
    tag64   = 4'd14;
    chk("w64.ssig0.valid", 64'(out_valid64), 64'(1'b1));
    chk("w64.ssig0.data",  out_data64,       64'h8100000000000000);
    chk("w64.ssig0.tag",   64'(out_tag64),   64'd13);
    chk("w64.ssig0.err",   64'(out_err64),   64'(1'b0));
    step();
    in_valid64 = 1'b0;
    chk("w64.bsig0.valid", 64'(out_valid64), 64'(1'b1));
    chk("w64.bsig0.data",  out_data64,       64'h0000001042000000);
    chk("w64.bsig0.tag",   64'(out_tag64),   64'd14);
    step();
    chk("w64.drain", 64'(out_valid64), 64'(1'b0));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
